// File: rtl/value_storage_pkg.sv
// Shared types and constants for the button-driven stack value editor.
package value_storage_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_RELEASE = 2'd1,
    REQ          = 2'd2,
    WAIT_ACK     = 2'd3
  } vs_state_e;

  localparam int BTN_ONE  = 0;
  localparam int BTN_ZERO = 1;
  localparam int BTN_POP  = 2;
  localparam int BTN_PUSH = 3;

  localparam int ERR_UFLOW = 0;
  localparam int ERR_OFLOW = 1;
  localparam int ERR_TMO   = 2;

  // Isolate the lowest pressed button so simultaneous presses resolve deterministically.
  function automatic logic [3:0] lowest_btn(input logic [3:0] b);
    return b & (~b + 4'd1);
  endfunction

endpackage

// File: rtl/vs_ack_timer.sv
// Counts WAIT_ACK cycles and flags expiry once TIMEOUT cycles pass without an ack.
module vs_ack_timer #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_disabled
      logic w_unused_inputs;
      assign w_unused_inputs = &{1'b0, clk, rst_n, clr, en};
      assign expired = 1'b0;
    end else begin : g_counter
      localparam int CW = $clog2(TIMEOUT + 1);
      logic [CW-1:0] r_cnt;
      logic          w_hit;

      assign w_hit   = (r_cnt == CW'(TIMEOUT - 1));
      assign expired = en && w_hit;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (clr) begin
          r_cnt <= '0;
        end else if (en && !w_hit) begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/value_storage_stack_ctrl.sv
// Button-driven value/pointer editor that pushes and pops the value to an external RAM stack.
module value_storage_stack_ctrl
  import value_storage_pkg::*;
#(
  parameter int          DATA_W  = 32,
  parameter int          ADDR_W  = 28,
  parameter int          LED_W   = 4,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        buttons,
  input  logic              tick,
  input  logic              mode,
  input  logic              err_clr,
  input  logic              ram_ready,
  input  logic              ram_rvalid,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [DATA_W-1:0] value,
  output logic [ADDR_W-1:0] sp,
  output logic [LED_W-1:0]  leds,
  output logic              busy,
  output logic [2:0]        error
);

  localparam logic [ADDR_W-1:0] SP_ONE = ADDR_W'(1);

  vs_state_e         r_state;
  vs_state_e         w_state_next;
  logic [DATA_W-1:0] r_value;
  logic [ADDR_W-1:0] r_sp;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_error;
  logic              r_op_push;

  logic [3:0] w_sel;
  logic       w_act;
  logic       w_sp_empty;
  logic       w_sp_full;
  logic       w_pop_go;
  logic       w_push_go;
  logic       w_req_start;
  logic       w_in_txn;
  logic       w_wait_ack;
  logic       w_ack;
  logic       w_expired;
  logic [2:0] w_err_set;

  assign w_sel       = lowest_btn(buttons);
  assign w_act       = (r_state == IDLE) && tick && (buttons != 4'd0);
  assign w_sp_empty  = (r_sp == '0);
  assign w_sp_full   = &r_sp;
  assign w_pop_go    = w_act && !mode && w_sel[BTN_POP]  && !w_sp_empty;
  assign w_push_go   = w_act && !mode && w_sel[BTN_PUSH] && !w_sp_full;
  assign w_req_start = w_pop_go || w_push_go;
  assign w_wait_ack  = (r_state == WAIT_ACK);
  assign w_in_txn    = (r_state == REQ) || w_wait_ack;
  assign w_ack       = w_in_txn && ram_ready;

  assign w_err_set[ERR_UFLOW] = w_act && !mode && w_sel[BTN_POP]  && w_sp_empty;
  assign w_err_set[ERR_OFLOW] = w_act && !mode && w_sel[BTN_PUSH] && w_sp_full;
  assign w_err_set[ERR_TMO]   = w_wait_ack && w_expired && !ram_ready;

  vs_ack_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_ack_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (w_req_start),
    .en     (w_wait_ack),
    .expired(w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:         if (w_act) w_state_next = w_req_start ? REQ : WAIT_RELEASE;
      WAIT_RELEASE: if (tick && (buttons == 4'd0)) w_state_next = IDLE;
      REQ:          w_state_next = ram_ready ? WAIT_RELEASE : WAIT_ACK;
      WAIT_ACK:     if (ram_ready || w_expired) w_state_next = WAIT_RELEASE;
      default:      w_state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    ram_read  = 1'b0;
    ram_write = 1'b0;
    case (r_state)
      REQ: begin
        busy      = 1'b1;
        ram_read  = !r_op_push;
        ram_write = r_op_push;
      end
      WAIT_ACK: busy = 1'b1;
      default: ;
    endcase
  end

  // Button edits, pointer updates on ack, and read-data capture for pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value   <= '0;
      r_sp      <= '0;
      r_addr    <= '0;
      r_error   <= '0;
      r_op_push <= 1'b0;
    end else begin
      r_error <= (err_clr ? 3'b000 : r_error) | w_err_set;
      if (w_act) begin
        if (!mode) begin
          if (w_sel[BTN_ONE]) begin
            r_value <= {r_value[DATA_W-2:0], 1'b1};
          end else if (w_sel[BTN_ZERO]) begin
            r_value <= {r_value[DATA_W-2:0], 1'b0};
          end else if (w_pop_go) begin
            r_addr    <= r_sp - SP_ONE;
            r_op_push <= 1'b0;
          end else if (w_push_go) begin
            r_addr    <= r_sp;
            r_op_push <= 1'b1;
          end
        end else begin
          if (w_sel[BTN_ONE]) begin
            r_sp <= {r_sp[ADDR_W-2:0], 1'b1};
          end else if (w_sel[BTN_ZERO]) begin
            r_sp <= {r_sp[ADDR_W-2:0], 1'b0};
          end else if (w_sel[BTN_POP]) begin
            r_sp <= '0;
          end else begin
            r_value <= '0;
          end
        end
      end
      if (w_ack) begin
        r_sp <= r_op_push ? (r_sp + SP_ONE) : (r_sp - SP_ONE);
      end
      if (w_in_txn && !r_op_push && ram_rvalid) begin
        r_value <= ram_rdata;
      end
    end
  end

  assign value     = r_value;
  assign ram_wdata = r_value;
  assign sp        = r_sp;
  assign ram_addr  = r_addr;
  assign error     = r_error;
  assign leds      = mode ? r_sp[LED_W-1:0] : r_value[LED_W-1:0];

endmodule

// File: tb/tb_value_storage_stack_ctrl.sv
// Directed bench with a transaction-level model checked every cycle plus literal pins.
module tb_value_storage_stack_ctrl;

  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int LW  = 4;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    buttons = 4'd0;
  logic          tick = 1'b0;
  logic          mode = 1'b0;
  logic          err_clr = 1'b0;
  logic          ram_ready = 1'b0;
  logic          ram_rvalid = 1'b0;
  logic [DW-1:0] ram_rdata = '0;
  logic          ram_read, ram_write, busy;
  logic [AW-1:0] ram_addr, sp;
  logic [DW-1:0] ram_wdata, value;
  logic [LW-1:0] leds;
  logic [2:0]    error;

  value_storage_stack_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .LED_W(LW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .buttons(buttons), .tick(tick), .mode(mode),
    .err_clr(err_clr), .ram_ready(ram_ready), .ram_rvalid(ram_rvalid),
    .ram_rdata(ram_rdata), .ram_read(ram_read), .ram_write(ram_write),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .value(value), .sp(sp),
    .leds(leds), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  // Model: architectural state as the user would see it between edges.
  logic [DW-1:0] m_value = '0;
  logic [AW-1:0] m_sp = '0;
  logic [AW-1:0] m_addr = '0;
  logic [2:0]    m_err = '0;
  bit            m_busy = 0, m_rd = 0, m_wr = 0, m_chk = 0;
  int            n_cmp = 0, n_bad = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_chk) begin
      cmp("value", value, m_value);
      cmp("wdata", ram_wdata, m_value);
      cmp("sp", 32'(sp), 32'(m_sp));
      cmp("addr", 32'(ram_addr), 32'(m_addr));
      cmp("error", 32'(error), 32'(m_err));
      cmp("busy", 32'(busy), 32'(m_busy));
      cmp("ram_read", 32'(ram_read), 32'(m_rd));
      cmp("ram_write", 32'(ram_write), 32'(m_wr));
      cmp("leds", 32'(leds), mode ? 32'(m_sp[LW-1:0]) : 32'(m_value[LW-1:0]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_mask(input logic [3:0] mask);
    buttons = mask;
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic press(input int b);
    logic [3:0] m;
    m = 4'd0;
    m[b] = 1'b1;
    press_mask(m);
  endtask

  task automatic release_btns();
    buttons = 4'd0;
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  // lat = cycle index (1 = the REQ cycle itself) at which ram_ready is presented.
  task automatic ram_op(input bit push, input int lat, input bit rv,
                        input logic [DW-1:0] rd, input bit late_rv);
    press(push ? 3 : 2);
    m_addr = push ? m_sp : m_sp - 4'd1;
    m_busy = 1;
    m_wr = push;
    m_rd = !push;
    for (int i = 1; i < lat; i++) begin
      step();
      m_wr = 0;
      m_rd = 0;
    end
    ram_ready = 1'b1;
    ram_rvalid = rv;
    ram_rdata = rd;
    step();
    ram_ready = 1'b0;
    ram_rvalid = 1'b0;
    m_wr = 0;
    m_rd = 0;
    m_busy = 0;
    m_sp = push ? m_sp + 4'd1 : m_sp - 4'd1;
    if (!push && rv) m_value = rd;
    $display("txn %s lat=%0d -> sp=%0d value=%h", push ? "push" : "pop", lat, sp, value);
    if (late_rv) begin
      ram_rvalid = 1'b1;
      ram_rdata = 32'h1234_5678;
      step();
      ram_rvalid = 1'b0;
    end
    release_btns();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    cmp("rst_value", value, 32'h0);
    cmp("rst_sp", 32'(sp), 32'h0);
    cmp("rst_err", 32'(error), 32'h0);
    cmp("rst_pulses", 32'({ram_read, ram_write, busy}), 32'h0);
    rst_n = 1'b1;
    m_chk = 1;
    step();

    press(0); m_value = {m_value[DW-2:0], 1'b1}; release_btns();
    press(1); m_value = {m_value[DW-2:0], 1'b0}; release_btns();
    press(0); m_value = {m_value[DW-2:0], 1'b1}; release_btns();
    $display("entry value=%h leds=%h", value, leds);
    cmp("entry_value", value, 32'h5);
    cmp("entry_leds", 32'(leds), 32'h5);

    buttons = 4'b0001;
    step(); step();
    buttons = 4'd0;
    step();

    ram_op(1, 3, 0, '0, 0);
    cmp("push_sp", 32'(sp), 32'h1);
    ram_op(0, 2, 1, 32'hDEAD_BEEF, 0);
    cmp("pop_value", value, 32'hDEAD_BEEF);
    cmp("pop_sp", 32'(sp), 32'h0);

    press(2); m_err[0] = 1'b1; release_btns();
    $display("underflow error=%b", error);
    cmp("uflow_err", 32'(error), 32'h1);

    ram_op(1, 1, 0, '0, 0);
    ram_op(0, 1, 0, '0, 1);
    cmp("late_rv_value", value, 32'hDEAD_BEEF);

    mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      press(0); m_sp = {m_sp[AW-2:0], 1'b1}; release_btns();
    end
    press(3); m_value = '0; release_btns();
    mode = 1'b0;
    press(3); m_err[1] = 1'b1; release_btns();
    $display("overflow sp=%0d error=%b", sp, error);
    cmp("oflow_err", 32'(error), 32'h3);
    cmp("oflow_sp", 32'(sp), 32'hF);

    err_clr = 1'b1; step(); err_clr = 1'b0; m_err = '0;
    cmp("clr_err", 32'(error), 32'h0);
    err_clr = 1'b1; press(3); err_clr = 1'b0; m_err = 3'b010; release_btns();
    $display("set-vs-clear error=%b", error);
    cmp("set_wins", 32'(error), 32'h2);
    err_clr = 1'b1; step(); err_clr = 1'b0; m_err = '0;

    mode = 1'b1; press(2); m_sp = '0; release_btns(); mode = 1'b0;
    press(0); m_value = {m_value[DW-2:0], 1'b1}; release_btns();
    press_mask(4'b1010); m_value = {m_value[DW-2:0], 1'b0}; release_btns();
    $display("lowest-wins value=%h sp=%0d", value, sp);
    cmp("lowest_wins", value, 32'h2);

    press(3); m_addr = m_sp; m_wr = 1; m_busy = 1;
    step(); m_wr = 0;
    repeat (7) step();
    cmp("tmo_busy", 32'(busy), 32'h1);
    step(); m_err[2] = 1'b1; m_busy = 0;
    $display("timeout error=%b sp=%0d", error, sp);
    cmp("tmo_err", 32'(error), 32'h4);
    ram_ready = 1'b1; step(); ram_ready = 1'b0;
    release_btns();
    cmp("tmo_sp", 32'(sp), 32'h0);

    press(3); m_addr = m_sp; m_wr = 1; m_busy = 1;
    step(); m_wr = 0;
    step();
    rst_n = 1'b0;
    #1;
    m_value = '0; m_sp = '0; m_addr = '0; m_err = '0; m_busy = 0;
    $display("reset mid-op value=%h sp=%0d busy=%b error=%b", value, sp, busy, error);
    cmp("rstmid_value", value, 32'h0);
    cmp("rstmid_busy", 32'(busy), 32'h0);
    cmp("rstmid_err", 32'(error), 32'h0);
    buttons = 4'd0;
    step();
    rst_n = 1'b1;
    tick = 1'b1; step(); tick = 1'b0;
    step();
    press(0); m_value = {m_value[DW-2:0], 1'b1}; release_btns();
    cmp("post_rst_value", value, 32'h1);
    step();
    m_chk = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
